// File: rtl/red_pitaya_pwm_dac_if.sv
// rtl/red_pitaya_pwm_dac_if.sv - config word and PWM output bundle of one slow analog output
interface red_pitaya_pwm_dac_if;
    logic [23:0] cfg;
    logic        pwm;
    logic        cyc;
    logic        upd;

    modport master (output cfg, input pwm, input cyc, input upd);
    modport slave  (input cfg, output pwm, output cyc, output upd);
endinterface

// File: rtl/red_pitaya_pwm_dac.sv
// rtl/red_pitaya_pwm_dac.sv - dithered PWM DAC, config double-buffered per 16-cycle super-period
// Optional dither: define RP_PWM_DAC_DITHER_EN to add B_s[bidx] to the base duty.
module red_pitaya_pwm_dac #(
    parameter int CCW = 156
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    red_pitaya_pwm_dac_if.slave   bus
);

    localparam logic [7:0] CNT_LAST = 8'(CCW - 1);
    localparam logic [8:0] DUTY_MAX = 9'(CCW);

    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [3:0] bidx;
    logic [3:0] bidx_nxt;
    logic [7:0] v_s;
    logic [7:0] v_nxt;
    logic       wrap;
    logic       load;
    logic [8:0] sum_nxt;
    logic [8:0] duty_nxt;

`ifdef RP_PWM_DAC_DITHER_EN
    logic [15:0] b_s;
    logic [15:0] b_nxt;
`else
    logic unused_cfg_b;
    assign unused_cfg_b = ^bus.cfg[15:0];
`endif

    // Outputs are registered from next-state values so they line up with cnt without latency.
    always_comb begin
        wrap     = (cnt == CNT_LAST);
        load     = wrap && (bidx == 4'd15);
        cnt_nxt  = wrap ? 8'd0 : cnt + 8'd1;
        bidx_nxt = wrap ? bidx + 4'd1 : bidx;
        v_nxt    = load ? bus.cfg[23:16] : v_s;
`ifdef RP_PWM_DAC_DITHER_EN
        b_nxt    = load ? bus.cfg[15:0] : b_s;
        sum_nxt  = {1'b0, v_nxt} + {8'd0, b_nxt[bidx_nxt]};
`else
        sum_nxt  = {1'b0, v_nxt};
`endif
        duty_nxt = (sum_nxt > DUTY_MAX) ? DUTY_MAX : sum_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= CNT_LAST;
            bidx    <= 4'd15;
            v_s     <= 8'd0;
`ifdef RP_PWM_DAC_DITHER_EN
            b_s     <= 16'd0;
`endif
            bus.pwm <= 1'b0;
            bus.cyc <= 1'b0;
            bus.upd <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            bidx    <= bidx_nxt;
            v_s     <= v_nxt;
`ifdef RP_PWM_DAC_DITHER_EN
            b_s     <= b_nxt;
`endif
            bus.pwm <= ({1'b0, cnt_nxt} < duty_nxt);
            bus.cyc <= (cnt_nxt == 8'd0);
            bus.upd <= (cnt_nxt == 8'd0) && (bidx_nxt == 4'd0);
        end
    end

endmodule

// File: tb/tb_red_pitaya_pwm_dac.sv
// tb/tb_red_pitaya_pwm_dac.sv - scoreboard bench: per-PWM-cycle duty, length and update pulses
module tb_red_pitaya_pwm_dac;

    localparam int CCW = 156;
    localparam int SUPER = 16 * CCW;

    typedef struct {
        int   high;
        logic upd;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    red_pitaya_pwm_dac_if bus ();

    red_pitaya_pwm_dac #(.CCW(CCW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: edge count since reset release defines cycle position and dither index.
    exp_t        sb[$];
    int          tk;
    logic [23:0] shadow;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tk = -1;
            sb.delete();
        end else begin
            int k;
            int d;
            tk++;
            if (tk % SUPER == 0)
                shadow = bus.cfg;
            if (tk % CCW == 0) begin
                k = (tk / CCW) % 16;
                d = int'(shadow[23:16]);
`ifdef RP_PWM_DAC_DITHER_EN
                d = d + int'(shadow[k]);
`endif
                if (d > CCW)
                    d = CCW;
                sb.push_back('{high: d, upd: (k == 0)});
            end
        end
    end

    // Monitor: measure each PWM cycle between cyc pulses and compare with the popped entry.
    exp_t cur;
    logic open = 1'b0;
    int   hi, len;
    logic seen_low, noncontig;

    always @(negedge clk_i) begin
        if (rst_i) begin
            open = 1'b0;
        end else begin
            check("upd_outside_cyc", int'(bus.upd && !bus.cyc), 0);
            if (bus.cyc) begin
                if (open) begin
                    check("cycle_high", hi, cur.high);
                    check("cycle_len", len, CCW);
                    check("pulse_contig", int'(noncontig), 0);
                end
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                    open = 1'b0;
                end else begin
                    cur = sb.pop_front();
                    check("upd_at_cyc", int'(bus.upd), int'(cur.upd));
                    open = 1'b1;
                    hi = 0;
                    len = 0;
                    seen_low = 1'b0;
                    noncontig = 1'b0;
                end
            end
            if (open) begin
                len++;
                if (bus.pwm) begin
                    hi++;
                    if (seen_low)
                        noncontig = 1'b1;
                end else begin
                    seen_low = 1'b1;
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic set_cfg(input logic [23:0] v);
        @(negedge clk_i);
        bus.cfg = v;
    endtask

    task automatic wait_upd();
        int n = 0;
        while (!bus.upd && n < SUPER + 10) begin
            @(negedge clk_i);
            n++;
        end
        check("upd_timeout", int'(bus.upd), 1);
    endtask

    task automatic release_reset();
        @(negedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("first_cyc", int'(bus.cyc), 1);
        check("first_upd", int'(bus.upd), 1);
    endtask

    initial begin
        bus.cfg = 24'h0F_0000;
        #1;
        check("rst_pwm", int'(bus.pwm), 0);
        check("rst_cyc", int'(bus.cyc), 0);
        check("rst_upd", int'(bus.upd), 0);
        run(3);
        release_reset();
        run(SUPER + 200);

        set_cfg(24'h4E_5555);
        run(2 * SUPER + 20);

        set_cfg(24'h4E_0000);
        run(SUPER + 20);
        wait_upd();
        run(5 * CCW + 30);
        bus.cfg = 24'h75_0000;
        run(2 * SUPER);

        set_cfg(24'h9C_FFFF);
        run(2 * SUPER);
        set_cfg(24'hFF_0000);
        run(2 * SUPER);
        set_cfg(24'h00_0000);
        run(2 * SUPER);
        set_cfg(24'h9B_0001);
        run(2 * SUPER);

        set_cfg(24'h0F_0000);
        run(SUPER + 20);
        begin
            int n = 0;
            while (!bus.pwm && n < 2 * CCW) begin
                @(negedge clk_i);
                n++;
            end
            check("pwm_high_timeout", int'(bus.pwm), 1);
        end
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_pwm", int'(bus.pwm), 0);
        check("async_rst_cyc", int'(bus.cyc), 0);
        check("async_rst_upd", int'(bus.upd), 0);
        bus.cfg = 24'h4E_5555;
        run(4);
        release_reset();
        run(SUPER + 200);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
